i2c_slave_regfile: RTL and testbench

- Parametrised successor to the single-byte fixed-response I2C slave.
- Exposes NUM_REGS byte-wide registers through the standard I2C register-pointer protocol (write pointer, write data with auto-increment, repeated-start read).
- Sits behind the top-level open-drain SDA buffer; all logic runs in the 25 MHz domain and oversamples SCL/SDA, with glitch filtering.
- Fabric side gets the register contents plus a per-write strobe.

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_pin_filter.sv | 66 ++++++
 rtl/i2c_slave_regfile.sv | 188 ++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-file slave: FSM states, bus events, ACK levels.
// No logic; types and constants only.
// Imported by the pin filter and the slave top.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDAT,
    ST_WDAT_ACK,
    ST_RDAT,
    ST_RDAT_ACK,
    ST_IGNORE
  } state_t;

  // At most one bus event per cycle; START/STOP win over SCL edges.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_START,
    EV_STOP,
    EV_RISE,
    EV_FALL
  } ev_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_pin_filter.sv
// Synchronises and glitch-filters SCL/SDA, then classifies bus events (START/STOP/RISE/FALL).
// Pin-to-filtered latency 2+FILT_LEN cycles; event pulse is combinational on the filtered level change.
// No backpressure: events are single-cycle pulses that must be consumed when presented.
module i2c_pin_filter
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output ev_t  o_ev,
  output logic o_sda
);

  localparam logic [2:0] CNT_MAX = 3'(FILT_LEN - 1);

  // Index 0 = SCL, index 1 = SDA.
  logic [1:0] r_s1, r_s2, r_f, r_fd;
  logic [2:0] r_cnt [2];
  logic [1:0] w_raw;

  assign w_raw = {i_sda, i_scl};
  assign o_sda = r_f[1];

  // Two-flop synchroniser, then accept a new level only after FILT_LEN consecutive differing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 2'b11;
      r_s2 <= 2'b11;
      r_f  <= 2'b11;
      r_fd <= 2'b11;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      r_fd <= r_f;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_f[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_f[i]   <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 3'd1;
        end
      end
    end
  end

  // Classify the filtered transition; an SDA edge with SCL held high is a START/STOP.
  always_comb begin
    o_ev = EV_NONE;
    if (r_f[0] && r_fd[0] && r_fd[1] && !r_f[1]) begin
      o_ev = EV_START;
    end else if (r_f[0] && r_fd[0] && !r_fd[1] && r_f[1]) begin
      o_ev = EV_STOP;
    end else if (r_f[0] && !r_fd[0]) begin
      o_ev = EV_RISE;
    end else if (!r_f[0] && r_fd[0]) begin
      o_ev = EV_FALL;
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing NUM_REGS byte registers via pointer-write / auto-increment / repeated-start read.
// SDA output updates one cycle after the filtered SCL fall; write strobe on the 8th data-bit rise.
// No fabric backpressure: wr_stb is a single-cycle pulse; the I2C master paces all transfers.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = 7'h77,
  parameter int          NUM_REGS = 8,
  parameter logic [7:0]  RST_VAL  = 8'h52,
  parameter int          FILT_LEN = 3,
  localparam int         PW       = $clog2(NUM_REGS)
) (
  input  logic                  clk_25,
  input  logic                  reset_n,
  input  logic                  mst_scl_in,
  input  logic                  mst_sda_in,
  output logic                  int_sda_oe,
  output logic [NUM_REGS*8-1:0] reg_q,
  output logic                  wr_stb,
  output logic [PW-1:0]         wr_idx,
  output logic [7:0]            wr_data,
  output logic                  busy
);

  localparam logic [8:0]    NREG9 = 9'(NUM_REGS);
  localparam logic [PW-1:0] LAST  = PW'(NUM_REGS - 1);

  ev_t           w_ev;
  logic          w_sda;
  logic [7:0]    w_byte;
  logic [7:0]    w_rd;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_ptr_ok;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [7:0]    r_sh;
  logic [PW-1:0] r_ptr;
  logic          r_ptr_wr;
  logic          r_rw;
  logic          r_mack;
  logic [7:0]    r_regs [NUM_REGS];

  i2c_pin_filter #(.FILT_LEN(FILT_LEN)) u_pins (
    .i_clk   (clk_25),
    .i_rst_n (reset_n),
    .i_scl   (mst_scl_in),
    .i_sda   (mst_sda_in),
    .o_ev    (w_ev),
    .o_sda   (w_sda)
  );

  assign w_byte    = {r_sh[6:0], w_sda};
  assign w_rd      = r_regs[r_ptr];
  assign w_ptr_nxt = (r_ptr == LAST) ? '0 : r_ptr + PW'(1);
  assign w_ptr_ok  = ({1'b0, r_sh} < NREG9);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_q
    assign reg_q[gi*8 +: 8] = r_regs[gi];
  end

  // Protocol FSM: bits are shifted on SCL rise, SDA drive changes on SCL fall.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_sh       <= '0;
      r_ptr      <= '0;
      r_ptr_wr   <= 1'b0;
      r_rw       <= 1'b0;
      r_mack     <= NACK;
      int_sda_oe <= 1'b1;
      wr_stb     <= 1'b0;
      wr_idx     <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RST_VAL;
    end else begin
      wr_stb <= 1'b0;
      if (w_ev == EV_START) begin
        r_state    <= ST_ADDR;
        r_cnt      <= '0;
        r_ptr_wr   <= 1'b0;
        int_sda_oe <= 1'b1;
        busy       <= 1'b1;
      end else if (w_ev == EV_STOP) begin
        r_state    <= ST_IDLE;
        int_sda_oe <= 1'b1;
        busy       <= 1'b0;
      end else if (w_ev == EV_RISE) begin
        case (r_state)
          ST_ADDR, ST_PTR, ST_WDAT: begin
            r_sh  <= w_byte;
            r_cnt <= r_cnt + 4'd1;
            if (r_state == ST_WDAT && r_cnt == 4'd7) begin
              r_regs[r_ptr] <= w_byte;
              wr_stb        <= 1'b1;
              wr_idx        <= r_ptr;
              wr_data       <= w_byte;
            end
          end
          ST_RDAT: r_cnt <= r_cnt + 4'd1;
          ST_RDAT_ACK: begin
            r_mack <= w_sda;
            if (w_sda == ACK) r_ptr <= w_ptr_nxt;
          end
          default: ;
        endcase
      end else if (w_ev == EV_FALL) begin
        case (r_state)
          ST_ADDR: begin
            if (r_cnt == 4'd8) begin
              r_cnt <= '0;
              if (r_sh[7:1] == SLV_ADDR) begin
                r_state    <= ST_ADDR_ACK;
                r_rw       <= r_sh[0];
                int_sda_oe <= ACK;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: begin
            r_cnt <= '0;
            if (r_rw) begin
              r_state    <= ST_RDAT;
              int_sda_oe <= w_rd[7];
              r_sh       <= {w_rd[6:0], 1'b0};
            end else begin
              r_state    <= r_ptr_wr ? ST_WDAT : ST_PTR;
              int_sda_oe <= 1'b1;
            end
          end
          ST_PTR: begin
            if (r_cnt == 4'd8) begin
              r_cnt <= '0;
              if (w_ptr_ok) begin
                r_ptr      <= r_sh[PW-1:0];
                r_ptr_wr   <= 1'b1;
                r_state    <= ST_PTR_ACK;
                int_sda_oe <= ACK;
              end else begin
                // Out-of-range pointer: leave SDA released (NACK) and drop the transfer.
                r_state <= ST_IGNORE;
              end
            end
          end
          ST_PTR_ACK, ST_WDAT_ACK: begin
            r_cnt      <= '0;
            r_state    <= ST_WDAT;
            int_sda_oe <= 1'b1;
          end
          ST_WDAT: begin
            if (r_cnt == 4'd8) begin
              r_cnt      <= '0;
              r_ptr      <= w_ptr_nxt;
              r_state    <= ST_WDAT_ACK;
              int_sda_oe <= ACK;
            end
          end
          ST_RDAT: begin
            if (r_cnt == 4'd8) begin
              r_cnt      <= '0;
              r_state    <= ST_RDAT_ACK;
              int_sda_oe <= 1'b1;
            end else begin
              int_sda_oe <= r_sh[7];
              r_sh       <= {r_sh[6:0], 1'b0};
            end
          end
          ST_RDAT_ACK: begin
            r_cnt <= '0;
            if (r_mack == ACK) begin
              // Pointer already advanced on the ACK rise, so w_rd is the next register.
              r_state    <= ST_RDAT;
              int_sda_oe <= w_rd[7];
              r_sh       <= {w_rd[6:0], 1'b0};
            end else begin
              r_state <= ST_IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

  localparam int         N   = 8;
  localparam logic [7:0] RST = 8'h52;
  localparam int         Q   = 8;

  logic           clk_25 = 1'b0;
  logic           reset_n = 1'b0;
  logic           m_scl = 1'b1;
  logic           m_sda = 1'b1;
  logic           w_bus;
  logic           int_sda_oe;
  logic [N*8-1:0] reg_q;
  logic           wr_stb;
  logic [2:0]     wr_idx;
  logic [7:0]     wr_data;
  logic           busy;

  int n_chk = 0;
  int n_pass = 0;
  int oe_low_cnt = 0;

  logic [15:0] exp_q [$];
  logic [7:0]  g_dat [$];
  logic [7:0]  mreg [N];
  int          mptr;

  assign w_bus = m_sda & int_sda_oe;

  always #20 clk_25 = ~clk_25;

  i2c_slave_regfile #(
    .SLV_ADDR (7'h77),
    .NUM_REGS (N),
    .RST_VAL  (RST),
    .FILT_LEN (3)
  ) dut (
    .clk_25     (clk_25),
    .reset_n    (reset_n),
    .mst_scl_in (m_scl),
    .mst_sda_in (w_bus),
    .int_sda_oe (int_sda_oe),
    .reg_q      (reg_q),
    .wr_stb     (wr_stb),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Write-strobe monitor: every strobe must match the oldest expected write.
  always @(negedge clk_25) begin
    if (reset_n && !int_sda_oe) oe_low_cnt++;
    if (reset_n && wr_stb) begin
      if (exp_q.size() == 0) begin
        check("wr_stb_spurious", 32'd1, 32'd0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("wr_idx", 32'(wr_idx), 32'(e[15:8]));
        check("wr_data", 32'(wr_data), 32'(e[7:0]));
        check("reg_q_at_wr", 32'(reg_q[wr_idx*8 +: 8]), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #8_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_25);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mreg[i] = RST;
    mptr = 0;
  endtask

  // One SCL clock: SDA set mid-low, bus sampled mid-high. Optional 1-cycle SCL glitch while low.
  task automatic bit_io(input logic v, input bit glitch, output logic got);
    cyc(Q);
    m_sda = v;
    if (glitch) begin
      cyc(3); m_scl = 1'b1; cyc(1); m_scl = 1'b0; cyc(Q - 4);
    end else begin
      cyc(Q);
    end
    m_scl = 1'b1;
    cyc(Q);
    @(negedge clk_25) got = w_bus;
    cyc(Q);
    m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (m_scl == 1'b0) begin
      cyc(Q); m_sda = 1'b1; cyc(Q); m_scl = 1'b1; cyc(Q);
    end else begin
      cyc(Q);
    end
    m_sda = 1'b0;
    cyc(2*Q);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    cyc(Q); m_sda = 1'b0; cyc(Q); m_scl = 1'b1; cyc(Q); m_sda = 1'b1; cyc(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack);
    logic got;
    for (int i = 7; i >= 0; i--) bit_io(b[i], glitch && (i == 7), got);
    bit_io(1'b1, 1'b0, got);
    ack = ~got;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic got;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, 1'b0, got);
      d = {d[6:0], got};
    end
    bit_io(mack, 1'b0, got);
  endtask

  // Write transaction: pointer byte then the bytes queued in g_dat.
  task automatic wr_txn(input int ptr, input bit do_stop, input bit glitch);
    logic ack;
    logic [7:0] d;
    bit valid;
    int first;
    i2c_start();
    check("busy_start", 32'(busy), 32'd1);
    send_byte(8'hEE, 1'b0, ack);
    check("addr_w_ack", 32'(ack), 32'd1);
    send_byte(8'(ptr), 1'b0, ack);
    valid = (ptr < N);
    check("ptr_ack", 32'(ack), 32'(valid));
    if (valid) mptr = ptr;
    first = 1;
    while (g_dat.size() > 0) begin
      d = g_dat.pop_front();
      if (valid) begin
        exp_q.push_back({8'(mptr), d});
        mreg[mptr] = d;
        mptr = (mptr + 1) % N;
      end
      send_byte(d, glitch && (first == 1), ack);
      check("wdat_ack", 32'(ack), 32'(valid));
      first = 0;
    end
    if (do_stop) begin
      i2c_stop();
      check("busy_stop", 32'(busy), 32'd0);
    end
  endtask

  // Read transaction: ACK all bytes but the last, then STOP.
  task automatic rd_txn(input int n);
    logic ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hEF, 1'b0, ack);
    check("addr_r_ack", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      e = mreg[mptr];
      recv_byte((i == n - 1) ? 1'b1 : 1'b0, d);
      check("rdat", 32'(d), 32'(e));
      if (i != n - 1) mptr = (mptr + 1) % N;
    end
    cyc(Q);
    @(negedge clk_25) check("rd_released", 32'(int_sda_oe), 32'd1);
    i2c_stop();
  endtask

  initial begin
    logic ack;
    int snap;
    model_reset();
    cyc(3);
    @(negedge clk_25);
    for (int i = 0; i < N; i++) check("rst_reg", 32'(reg_q[i*8 +: 8]), 32'(RST));
    check("rst_oe", 32'(int_sda_oe), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stb", 32'(wr_stb), 32'd0);
    check("rst_idx", 32'(wr_idx), 32'd0);
    check("rst_wdata", 32'(wr_data), 32'd0);
    reset_n = 1'b1;
    cyc(10);

    // Single write to register 3.
    g_dat.push_back(8'hA5);
    wr_txn(3, 1'b1, 1'b0);
    check("reg3", 32'(reg_q[3*8 +: 8]), 32'hA5);

    // Auto-increment across the wrap point.
    g_dat.push_back(8'h11); g_dat.push_back(8'h22);
    wr_txn(7, 1'b1, 1'b0);
    check("reg7", 32'(reg_q[7*8 +: 8]), 32'h11);
    check("reg0", 32'(reg_q[0 +: 8]), 32'h22);

    // Pointer write, repeated START, 3-byte read with wrap.
    wr_txn(6, 1'b0, 1'b0);
    rd_txn(3);

    // Address mismatch: SDA never driven, no strobes.
    snap = oe_low_cnt;
    i2c_start();
    send_byte(8'hA0, 1'b0, ack);
    check("mismatch_nack", 32'(ack), 32'd0);
    send_byte(8'h55, 1'b0, ack);
    check("mismatch_data_nack", 32'(ack), 32'd0);
    check("mismatch_oe_quiet", 32'(oe_low_cnt - snap), 32'd0);
    i2c_stop();

    // Out-of-range pointer: NACK, data ignored, pointer kept.
    g_dat.push_back(8'h33); g_dat.push_back(8'h44);
    wr_txn(9, 1'b1, 1'b0);
    rd_txn(1);

    // SCL glitch inside the first data bit must not count as a clock.
    g_dat.push_back(8'h3C);
    wr_txn(2, 1'b1, 1'b1);
    check("reg2_glitch", 32'(reg_q[2*8 +: 8]), 32'h3C);

    // Randomised mix of writes, pointer+read and plain reads.
    for (int it = 0; it < 12; it++) begin
      int k;
      k = $urandom_range(0, 2);
      if (k == 0) begin
        int n;
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) g_dat.push_back(8'($urandom));
        wr_txn($urandom_range(0, 9), 1'b1, 1'b0);
      end else if (k == 1) begin
        wr_txn($urandom_range(0, 9), 1'b0, 1'b0);
        rd_txn($urandom_range(1, 3));
      end else begin
        rd_txn($urandom_range(1, 3));
      end
    end

    // Reset in the middle of a read while the slave drives a 0 bit.
    g_dat.push_back(8'h00);
    wr_txn(1, 1'b1, 1'b0);
    wr_txn(1, 1'b0, 1'b0);
    i2c_start();
    send_byte(8'hEF, 1'b0, ack);
    check("addr_r_ack_pre_rst", 32'(ack), 32'd1);
    cyc(12);
    @(negedge clk_25) check("rd_drive0", 32'(int_sda_oe), 32'd0);
    reset_n = 1'b0;
    #1 check("rst_release_sda", 32'(int_sda_oe), 32'd1);
    check("rst_busy_mid", 32'(busy), 32'd0);
    model_reset();
    cyc(2);
    @(negedge clk_25) check("rst_reg1_mid", 32'(reg_q[1*8 +: 8]), 32'(RST));
    reset_n = 1'b1;
    m_scl = 1'b1;
    cyc(2*Q);
    m_sda = 1'b1;
    cyc(2*Q);

    // Function resumes after reset.
    g_dat.push_back(8'h5A);
    wr_txn(4, 1'b1, 1'b0);
    wr_txn(3, 1'b0, 1'b0);
    rd_txn(2);

    cyc(10);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < N; i++) check("final_reg", 32'(reg_q[i*8 +: 8]), 32'(mreg[i]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
